// File: rtl/tetris_pkg.sv
// Shared definitions for the Tetris playfield, piece controller and VGA renderer.
// Holds the board geometry, the game-board state encodings and the
// cleared-lines -> points table.
package tetris_pkg;

    localparam int unsigned BOARD_W = 10;
    localparam int unsigned BOARD_H = 12;
    localparam logic [BOARD_W-1:0] FULL_ROW = 10'h3FF;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StGen   = 3'd1,
        StPlay  = 3'd2,
        StLock  = 3'd3,
        StScan  = 3'd4,
        StShift = 3'd5,
        StScore = 3'd6,
        StOver  = 3'd7
    } game_state_e;

    // Points awarded for clearing k rows with a single piece.
    function automatic logic [3:0] line_points(input logic [2:0] k);
        logic [3:0] pts;
        case (k)
            3'd0:    pts = 4'd0;
            3'd1:    pts = 4'd1;
            3'd2:    pts = 4'd3;
            3'd3:    pts = 4'd5;
            default: pts = 4'd8;
        endcase
        return pts;
    endfunction

endpackage

// File: rtl/line_score.sv
// Combinational score update for one locked piece.
// Ports:
//   k_i      rows cleared by this piece (0..4)
//   score_i  current score;  score_o  score + line_points(k), saturating
//   lines_i  current lines;  lines_o  lines + k, saturating
module line_score
    import tetris_pkg::*;
#(
    parameter int unsigned SCORE_W = 16,
    parameter int unsigned LINES_W = 8
) (
    input  logic [2:0]         k_i,
    input  logic [SCORE_W-1:0] score_i,
    input  logic [LINES_W-1:0] lines_i,
    output logic [SCORE_W-1:0] score_o,
    output logic [LINES_W-1:0] lines_o
);

    logic [SCORE_W:0] score_sum;
    logic [LINES_W:0] lines_sum;

    assign score_sum = {1'b0, score_i} + (SCORE_W+1)'(line_points(k_i));
    assign lines_sum = {1'b0, lines_i} + (LINES_W+1)'(k_i);

    // Carry out of the top bit means overflow: clamp to all-ones.
    assign score_o = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
    assign lines_o = lines_sum[LINES_W] ? '1 : lines_sum[LINES_W-1:0];

endmodule

// File: rtl/game_board.sv
// Playfield owner: locks landed pieces into the 10x12 board, clears and
// collapses full rows, keeps score/lines and sequences start / game over.
// Ports:
//   Clk, Reset_n            clock, async active-low reset
//   Start, Ack              begin game (IDLE only), acknowledge game over (OVER only)
//   bottom_flag, top_flag   landed piece present / piece reaches top row
//   x1..x4, y1..y4          landed piece cells
//   arr0..arr11             board rows, row 0 at the bottom
//   gen_flag                one-cycle new-piece request
//   score, lines            accumulated points and cleared rows
//   game_over, state        OVER indicator and raw state code
module game_board
    import tetris_pkg::*;
#(
    parameter int unsigned SCORE_W = 16,
    parameter int unsigned LINES_W = 8
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               Start,
    input  logic               Ack,
    input  logic               bottom_flag,
    input  logic               top_flag,
    input  logic [3:0]         x1,
    input  logic [3:0]         x2,
    input  logic [3:0]         x3,
    input  logic [3:0]         x4,
    input  logic [3:0]         y1,
    input  logic [3:0]         y2,
    input  logic [3:0]         y3,
    input  logic [3:0]         y4,
    output logic [9:0]         arr0,
    output logic [9:0]         arr1,
    output logic [9:0]         arr2,
    output logic [9:0]         arr3,
    output logic [9:0]         arr4,
    output logic [9:0]         arr5,
    output logic [9:0]         arr6,
    output logic [9:0]         arr7,
    output logic [9:0]         arr8,
    output logic [9:0]         arr9,
    output logic [9:0]         arr10,
    output logic [9:0]         arr11,
    output logic               gen_flag,
    output logic [SCORE_W-1:0] score,
    output logic [LINES_W-1:0] lines,
    output logic               game_over,
    output logic [2:0]         state
);

    localparam logic [4:0] LAST_ROW = 5'(BOARD_H - 1);

    game_state_e          state_q, state_d;
    logic [BOARD_W-1:0]   board_q [BOARD_H];
    logic [BOARD_W-1:0]   board_d [BOARD_H];
    logic [SCORE_W-1:0]   score_q, score_d, score_sum;
    logic [LINES_W-1:0]   lines_q, lines_d, lines_sum;
    logic [3:0]           r_q, r_d;
    logic [2:0]           k_q, k_d;
    logic                 top_q, top_d;
    logic                 gen_q, gen_d;
    logic [3:0]           cx_q [4];
    logic [3:0]           cx_d [4];
    logic [3:0]           cy_q [4];
    logic [3:0]           cy_d [4];

    line_score #(
        .SCORE_W (SCORE_W),
        .LINES_W (LINES_W)
    ) u_line_score (
        .k_i     (k_q),
        .score_i (score_q),
        .lines_i (lines_q),
        .score_o (score_sum),
        .lines_o (lines_sum)
    );

    always_comb begin
        state_d = state_q;
        board_d = board_q;
        score_d = score_q;
        lines_d = lines_q;
        r_d     = r_q;
        k_d     = k_q;
        top_d   = top_q;
        cx_d    = cx_q;
        cy_d    = cy_q;

        unique case (state_q)
            StIdle: begin
                if (Start) state_d = StGen;
            end
            StGen: begin
                state_d = StPlay;
            end
            StPlay: begin
                // Capture the piece so LOCK does not depend on the controller
                // still holding it.
                if (bottom_flag) begin
                    top_d   = top_flag;
                    cx_d[0] = x1;
                    cx_d[1] = x2;
                    cx_d[2] = x3;
                    cx_d[3] = x4;
                    cy_d[0] = y1;
                    cy_d[1] = y2;
                    cy_d[2] = y3;
                    cy_d[3] = y4;
                    state_d = StLock;
                end
            end
            StLock: begin
                for (int c = 0; c < 4; c++) begin
                    if (cx_q[c] < 4'(BOARD_W) && cy_q[c] < 4'(BOARD_H)) begin
                        board_d[cy_q[c]][cx_q[c]] = 1'b1;
                    end
                end
                r_d     = '0;
                k_d     = '0;
                state_d = top_q ? StOver : StScan;
            end
            StScan: begin
                // After k collapses the top k rows are known empty, so the scan
                // can stop k rows early; this keeps the scan at 12 cycles total.
                if (board_q[r_q] == FULL_ROW) begin
                    state_d = StShift;
                end else if (({1'b0, r_q} + {2'b00, k_q}) >= LAST_ROW) begin
                    state_d = StScore;
                end else begin
                    r_d = r_q + 4'd1;
                end
            end
            StShift: begin
                for (int i = 0; i < BOARD_H - 1; i++) begin
                    if (4'(i) >= r_q) board_d[i] = board_q[i+1];
                end
                board_d[BOARD_H-1] = '0;
                k_d     = k_q + 3'd1;
                state_d = StScan;
            end
            StScore: begin
                score_d = score_sum;
                lines_d = lines_sum;
                state_d = StGen;
            end
            StOver: begin
                if (Ack) begin
                    board_d = '{default: '0};
                    score_d = '0;
                    lines_d = '0;
                    state_d = StIdle;
                end
            end
        endcase

        gen_d = (state_d == StGen);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= StIdle;
            board_q <= '{default: '0};
            score_q <= '0;
            lines_q <= '0;
            r_q     <= '0;
            k_q     <= '0;
            top_q   <= 1'b0;
            gen_q   <= 1'b0;
            cx_q    <= '{default: '0};
            cy_q    <= '{default: '0};
        end else begin
            state_q <= state_d;
            board_q <= board_d;
            score_q <= score_d;
            lines_q <= lines_d;
            r_q     <= r_d;
            k_q     <= k_d;
            top_q   <= top_d;
            gen_q   <= gen_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
        end
    end

    assign arr0      = board_q[0];
    assign arr1      = board_q[1];
    assign arr2      = board_q[2];
    assign arr3      = board_q[3];
    assign arr4      = board_q[4];
    assign arr5      = board_q[5];
    assign arr6      = board_q[6];
    assign arr7      = board_q[7];
    assign arr8      = board_q[8];
    assign arr9      = board_q[9];
    assign arr10     = board_q[10];
    assign arr11     = board_q[11];
    assign gen_flag  = gen_q;
    assign score     = score_q;
    assign lines     = lines_q;
    assign game_over = (state_q == StOver);
    assign state     = state_q;

endmodule

// File: tb/tb_game_board.sv
// Bench for game_board: each landed piece pushes its expected board, score,
// lines and gen_flag latency; the entry is popped when gen_flag arrives.
module tb_game_board;
    import tetris_pkg::*;

    logic        Clk, Reset_n, Start, Ack, bottom_flag, top_flag;
    logic [3:0]  x1, x2, x3, x4, y1, y2, y3, y4;
    logic [9:0]  arr0, arr1, arr2, arr3, arr4, arr5, arr6, arr7, arr8, arr9, arr10, arr11;
    logic        gen_flag, game_over;
    logic [15:0] score;
    logic [7:0]  lines;
    logic [2:0]  state;
    logic [119:0] dut_board;

    assign dut_board = {arr11, arr10, arr9, arr8, arr7, arr6, arr5, arr4, arr3, arr2, arr1, arr0};

    game_board #(.SCORE_W(16), .LINES_W(8)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Ack(Ack),
        .bottom_flag(bottom_flag), .top_flag(top_flag),
        .x1(x1), .x2(x2), .x3(x3), .x4(x4), .y1(y1), .y2(y2), .y3(y3), .y4(y4),
        .arr0(arr0), .arr1(arr1), .arr2(arr2), .arr3(arr3), .arr4(arr4), .arr5(arr5),
        .arr6(arr6), .arr7(arr7), .arr8(arr8), .arr9(arr9), .arr10(arr10), .arr11(arr11),
        .gen_flag(gen_flag), .score(score), .lines(lines), .game_over(game_over),
        .state(state)
    );

    typedef struct packed {
        logic [119:0] board;
        logic [15:0]  score;
        logic [7:0]   lines;
        logic [7:0]   lat;
    } exp_t;

    exp_t        sb_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [9:0]  mb [12];
    int          m_score, m_lines;
    int          tbl [5] = '{0, 1, 3, 5, 8};

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [119:0] pack_model();
        logic [119:0] v;
        for (int i = 0; i < 12; i++) v[i*10 +: 10] = mb[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 12; i++) mb[i] = '0;
        m_score = 0;
        m_lines = 0;
    endtask

    task automatic model_lock(input logic [15:0] xs, input logic [15:0] ys);
        for (int c = 0; c < 4; c++) begin
            if (xs[4*c +: 4] < 4'd10 && ys[4*c +: 4] < 4'd12) mb[ys[4*c +: 4]][xs[4*c +: 4]] = 1'b1;
        end
    endtask

    // Remove full rows and let the survivors fall, keeping their order.
    task automatic model_clear(output int k);
        logic [9:0] nb [12];
        int n;
        n = 0;
        k = 0;
        for (int i = 0; i < 12; i++) nb[i] = '0;
        for (int i = 0; i < 12; i++) begin
            if (mb[i] == 10'h3FF) k++;
            else begin
                nb[n] = mb[i];
                n++;
            end
        end
        for (int i = 0; i < 12; i++) mb[i] = nb[i];
    endtask

    task automatic drive_cells(input logic [15:0] xs, input logic [15:0] ys);
        {x4, x3, x2, x1} = xs;
        {y4, y3, y2, y1} = ys;
    endtask

    // Called at a negedge in PLAY. xs/ys hold cell4..cell1, MSB first.
    task automatic land_piece(input logic [15:0] xs, input logic [15:0] ys, input string tag);
        exp_t e;
        int   k, m;
        bit   seen;
        model_lock(xs, ys);
        model_clear(k);
        m_score = m_score + tbl[k];
        if (m_score > 65535) m_score = 65535;
        m_lines = m_lines + k;
        if (m_lines > 255) m_lines = 255;
        e.board = pack_model();
        e.score = 16'(m_score);
        e.lines = 8'(m_lines);
        e.lat   = 8'(14 + k);
        sb_q.push_back(e);

        drive_cells(xs, ys);
        top_flag    = 1'b0;
        bottom_flag = 1'b1;
        @(negedge Clk);
        bottom_flag = 1'b0;
        m = 0;
        seen = 0;
        while (!seen && m < 60) begin
            if (gen_flag) seen = 1;
            else begin
                @(negedge Clk);
                m++;
            end
        end
        n_cmp++;
        if (!seen || sb_q.size() == 0) begin
            n_bad++;
            $display("FAIL %s gen_timeout: no gen_flag within %0d cycles", tag, m);
        end else begin
            e = sb_q.pop_front();
            if (8'(m) !== e.lat) begin
                n_bad++;
                $display("FAIL %s latency: got %0d expected %0d", tag, m, e.lat);
            end
            n_cmp++;
            if (dut_board !== e.board) begin
                n_bad++;
                $display("FAIL %s board: got %h expected %h", tag, dut_board, e.board);
            end
            n_cmp++;
            if (score !== e.score) begin
                n_bad++;
                $display("FAIL %s score: got %0d expected %0d", tag, score, e.score);
            end
            n_cmp++;
            if (lines !== e.lines) begin
                n_bad++;
                $display("FAIL %s lines: got %0d expected %0d", tag, lines, e.lines);
            end
            @(negedge Clk);
            n_cmp++;
            if (gen_flag !== 1'b0 || state !== StPlay) begin
                n_bad++;
                $display("FAIL %s gen_one_cycle: got gen=%b state=%0d expected gen=0 state=%0d",
                         tag, gen_flag, state, StPlay);
            end
        end
    endtask

    task automatic land_pair(input logic [3:0] c0, input string tag);
        logic [3:0] c1;
        c1 = c0 + 4'd1;
        land_piece({c1, c0, c1, c0}, {4'd1, 4'd1, 4'd0, 4'd0}, tag);
    endtask

    task automatic check_reset_values(input string tag);
        n_cmp++;
        if (dut_board !== '0) begin
            n_bad++;
            $display("FAIL %s board: got %h expected 0", tag, dut_board);
        end
        n_cmp++;
        if (score !== 16'd0 || lines !== 8'd0) begin
            n_bad++;
            $display("FAIL %s score_lines: got %0d/%0d expected 0/0", tag, score, lines);
        end
        n_cmp++;
        if (gen_flag !== 1'b0 || game_over !== 1'b0) begin
            n_bad++;
            $display("FAIL %s flags: got gen=%b over=%b expected 0/0", tag, gen_flag, game_over);
        end
        n_cmp++;
        if (state !== StIdle) begin
            n_bad++;
            $display("FAIL %s state: got %0d expected %0d", tag, state, StIdle);
        end
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        Start = 0; Ack = 0; bottom_flag = 0; top_flag = 0;
        drive_cells('0, '0);
        model_reset();
        repeat (3) @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);
        check_reset_values("reset");
    endtask

    // Start held for two edges; the second edge lands in GEN and is ignored.
    task automatic test_start();
        Start = 1'b1;
        @(negedge Clk);
        n_cmp++;
        if (gen_flag !== 1'b1 || state !== StGen) begin
            n_bad++;
            $display("FAIL start_gen: got gen=%b state=%0d expected gen=1 state=%0d",
                     gen_flag, state, StGen);
        end
        @(negedge Clk);
        Start = 1'b0;
        n_cmp++;
        if (gen_flag !== 1'b0 || state !== StPlay || dut_board !== '0) begin
            n_bad++;
            $display("FAIL start_play: got gen=%b state=%0d board=%h expected 0/%0d/0",
                     gen_flag, state, dut_board, StPlay);
        end
    endtask

    task automatic test_clear_two();
        land_pair(4'd0, "pre_c0");
        land_pair(4'd2, "pre_c2");
        land_pair(4'd6, "pre_c6");
        land_pair(4'd8, "pre_c8");
        n_cmp++;
        if (arr0 !== 10'h3CF || arr1 !== 10'h3CF) begin
            n_bad++;
            $display("FAIL preload: got %h/%h expected 3cf/3cf", arr0, arr1);
        end
        land_pair(4'd4, "clear_two");
        n_cmp++;
        if (score !== 16'd3 || lines !== 8'd2 || dut_board !== '0) begin
            n_bad++;
            $display("FAIL clear_two_result: got score=%0d lines=%0d board=%h expected 3/2/0",
                     score, lines, dut_board);
        end
    endtask

    // Rows 0 and 2 fill on the last piece; out-of-range cells must be dropped.
    task automatic test_split_rows();
        land_piece({4'd3, 4'd2, 4'd1, 4'd0}, {4'd0, 4'd0, 4'd0, 4'd0}, "split_a");
        land_piece({4'd8, 4'd7, 4'd6, 4'd4}, {4'd0, 4'd0, 4'd0, 4'd0}, "split_b");
        land_piece({4'd12, 4'd9, 4'd0, 4'd9}, {4'd0, 4'd3, 4'd1, 4'd0}, "split_c_x12");
        land_piece({4'd3, 4'd2, 4'd1, 4'd0}, {4'd2, 4'd2, 4'd2, 4'd2}, "split_d");
        land_piece({4'd8, 4'd7, 4'd6, 4'd4}, {4'd2, 4'd2, 4'd2, 4'd2}, "split_e");
        land_piece({4'd12, 4'd15, 4'd3, 4'd9}, {4'd2, 4'd1, 4'd13, 4'd2}, "split_f_drop");
        land_piece({4'd12, 4'd5, 4'd5, 4'd5}, {4'd4, 4'd0, 4'd2, 4'd0}, "split_g");
        n_cmp++;
        if (arr0 !== 10'h001 || arr1 !== 10'h200 || score !== 16'd6) begin
            n_bad++;
            $display("FAIL split_result: got %h/%h score=%0d expected 001/200 score=6",
                     arr0, arr1, score);
        end
    endtask

    task automatic test_reset_in_shift();
        bit hit;
        land_piece({4'd4, 4'd3, 4'd2, 4'd1}, {4'd0, 4'd0, 4'd0, 4'd0}, "shift_pre1");
        land_piece({4'd8, 4'd7, 4'd6, 4'd5}, {4'd0, 4'd0, 4'd0, 4'd0}, "shift_pre2");
        drive_cells({4'd15, 4'd15, 4'd15, 4'd9}, {4'd15, 4'd15, 4'd15, 4'd0});
        bottom_flag = 1'b1;
        hit = 0;
        for (int i = 0; i < 20 && !hit; i++) begin
            @(negedge Clk);
            bottom_flag = 1'b0;
            if (state == StShift) hit = 1;
        end
        n_cmp++;
        if (!hit) begin
            n_bad++;
            $display("FAIL shift_reach: got no SHIFT state expected SHIFT within 20 cycles");
        end
        Reset_n = 1'b0;
        @(negedge Clk);
        check_reset_values("reset_in_shift");
        Reset_n = 1'b1;
        model_reset();
        @(negedge Clk);
    endtask

    task automatic test_game_over();
        int gens;
        model_lock({4'd5, 4'd4, 4'd5, 4'd4}, {4'd11, 4'd11, 4'd10, 4'd10});
        drive_cells({4'd5, 4'd4, 4'd5, 4'd4}, {4'd11, 4'd11, 4'd10, 4'd10});
        top_flag    = 1'b1;
        bottom_flag = 1'b1;
        @(negedge Clk);
        bottom_flag = 1'b0;
        top_flag    = 1'b0;
        gens = 0;
        repeat (20) begin
            @(negedge Clk);
            if (gen_flag) gens++;
        end
        n_cmp++;
        if (gens !== 0) begin
            n_bad++;
            $display("FAIL over_no_gen: got %0d pulses expected 0", gens);
        end
        n_cmp++;
        if (game_over !== 1'b1 || state !== StOver) begin
            n_bad++;
            $display("FAIL over_state: got over=%b state=%0d expected 1/%0d",
                     game_over, state, StOver);
        end
        n_cmp++;
        if (dut_board !== pack_model() || arr11 !== 10'h030) begin
            n_bad++;
            $display("FAIL over_board: got %h expected %h", dut_board, pack_model());
        end
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        @(negedge Clk);
        n_cmp++;
        if (state !== StOver || gen_flag !== 1'b0 || score !== 16'd3) begin
            n_bad++;
            $display("FAIL over_start_ignored: got state=%0d gen=%b score=%0d expected %0d/0/3",
                     state, gen_flag, score, StOver);
        end
        Ack = 1'b1;
        @(negedge Clk);
        Ack = 1'b0;
        model_reset();
        check_reset_values("ack_clear");
    endtask

    initial begin
        test_reset();
        test_start();
        test_clear_two();
        test_split_rows();
        test_reset_in_shift();
        test_start();
        land_pair(4'd4, "square");
        n_cmp++;
        if (arr0 !== 10'h030 || arr1 !== 10'h030 || score !== 16'd0) begin
            n_bad++;
            $display("FAIL square_result: got %h/%h score=%0d expected 030/030 score=0",
                     arr0, arr1, score);
        end
        land_pair(4'd0, "refill_c0");
        land_pair(4'd2, "refill_c2");
        land_pair(4'd6, "refill_c6");
        land_pair(4'd8, "refill_c8");
        test_game_over();
        test_start();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
